// File: rtl/add4_share_ctrl_if.sv
// Bus bundle between two requesters, the external 4-bit adder slice
// and the shared-slice sequencer.
interface add4_share_ctrl_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         ack0;
    logic         ack1;
    logic [1:0]   gnt;
    logic         busy;
    logic [W-1:0] sum;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        output add_sum, add_cout,
        input  ack0, ack1, gnt, busy, sum, cout,
        input  add_a, add_b, add_cin
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        input  add_sum, add_cout,
        output ack0, ack1, gnt, busy, sum, cout,
        output add_a, add_b, add_cin
    );
endinterface

// File: rtl/add4_share_ctrl.sv
// Round-robin sequencer for a shared 4-bit adder slice; runs
// multi-nibble adds LSB first with an internal carry register.
module add4_share_ctrl #(
    parameter int NIBBLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    add4_share_ctrl_if.slave bus
);
    localparam int         W     = 4 * NIBBLES;
    localparam logic [1:0] KLAST = 2'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] res;
    logic [W-1:0] res_nx;
    logic [W-1:0] sum_r;
    logic         cout_r;
    logic         carry;
    logic         last;
    logic [1:0]   k;
    logic [1:0]   gnt;
    logic [4:0]   sh;
    logic         pick1;
    logic         ack0;
    logic         ack1;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;

    assign sh = {1'b0, k, 2'b00};

    // Tie goes to whoever was not served last
    assign pick1 = bus.req1 & (~bus.req0 | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ack0     = 1'b0;
        ack1     = 1'b0;
        add_a    = 4'h0;
        add_b    = 4'h0;
        add_cin  = 1'b0;
        res_nx   = res;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) state_nx = CALC;
            end
            CALC: begin
                add_a   = 4'(opa >> sh);
                add_b   = 4'(opb >> sh);
                add_cin = carry;
                res_nx  = (res & ~(W'(4'hF) << sh))
                        | (W'(bus.add_sum) << sh);
                if (k == KLAST) state_nx = DONE;
            end
            DONE: begin
                ack0     = gnt[0];
                ack1     = gnt[1];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            carry  <= 1'b0;
            last   <= 1'b1;
            k      <= 2'd0;
            gnt    <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt   <= pick1 ? 2'b10 : 2'b01;
                        opa   <= pick1 ? bus.a1 : bus.a0;
                        opb   <= pick1 ? bus.b1 : bus.b0;
                        carry <= 1'b0;
                        k     <= 2'd0;
                    end
                end
                CALC: begin
                    res   <= res_nx;
                    carry <= bus.add_cout;
                    k     <= k + 2'd1;
                    if (k == KLAST) begin
                        sum_r  <= res_nx;
                        cout_r <= bus.add_cout;
                    end
                end
                DONE: begin
                    last <= gnt[1];
                    gnt  <= 2'b00;
                end
                default: gnt <= 2'b00;
            endcase
        end
    end

    assign bus.ack0    = ack0;
    assign bus.ack1    = ack1;
    assign bus.gnt     = gnt;
    assign bus.busy    = (state != IDLE);
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.add_a   = add_a;
    assign bus.add_b   = add_b;
    assign bus.add_cin = add_cin;
endmodule

// File: tb/tb_add4_share_ctrl.sv
// Directed bench for add4_share_ctrl: a 2-nibble and a 1-nibble
// instance, each wired to a behavioural 4-bit adder slice.
module tb_add4_share_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    add4_share_ctrl_if #(.NIBBLES(2)) bus2 ();
    add4_share_ctrl_if #(.NIBBLES(1)) bus1 ();

    add4_share_ctrl #(.NIBBLES(2)) u2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    add4_share_ctrl #(.NIBBLES(1)) u1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    assign {bus2.add_cout, bus2.add_sum} =
        {1'b0, bus2.add_a} + {1'b0, bus2.add_b} + {4'b0, bus2.add_cin};
    assign {bus1.add_cout, bus1.add_sum} =
        {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'b0, bus1.add_cin};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ph;
        int own;
        rst_n     = 1'b0;
        bus2.req0 = 1'b0;
        bus2.req1 = 1'b0;
        bus2.a0   = '0;
        bus2.b0   = '0;
        bus2.a1   = '0;
        bus2.b1   = '0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus1.a0   = '0;
        bus1.b0   = '0;
        bus1.a1   = '0;
        bus1.b1   = '0;

        step();
        step();
        check("rst_gnt",  32'(bus2.gnt), 32'h0);
        check("rst_ack0", 32'(bus2.ack0), 32'h0);
        check("rst_ack1", 32'(bus2.ack1), 32'h0);
        check("rst_busy", 32'(bus2.busy), 32'h0);
        check("rst_sum",  32'(bus2.sum), 32'h0);
        check("rst_cout", 32'(bus2.cout), 32'h0);
        check("rst_adda", 32'(bus2.add_a), 32'h0);
        check("rst_cin",  32'(bus2.add_cin), 32'h0);
        rst_n = 1'b1;
        step();

        // basic add 0x3C + 0x45
        bus2.a0   = 8'h3C;
        bus2.b0   = 8'h45;
        bus2.req0 = 1'b1;
        step();
        check("bas_gnt1",  32'(bus2.gnt), 32'h1);
        check("bas_busy1", 32'(bus2.busy), 32'h1);
        check("bas_adda1", 32'(bus2.add_a), 32'hC);
        check("bas_addb1", 32'(bus2.add_b), 32'h5);
        check("bas_cin1",  32'(bus2.add_cin), 32'h0);
        step();
        check("bas_adda2", 32'(bus2.add_a), 32'h3);
        check("bas_cin2",  32'(bus2.add_cin), 32'h1);
        check("bas_ack2",  32'(bus2.ack0), 32'h0);
        step();
        check("bas_ack3",  32'(bus2.ack0), 32'h1);
        check("bas_sum",   32'(bus2.sum), 32'h81);
        check("bas_cout",  32'(bus2.cout), 32'h0);
        check("bas_gnt3",  32'(bus2.gnt), 32'h1);
        check("bas_cin3",  32'(bus2.add_cin), 32'h0);
        bus2.req0 = 1'b0;
        step();
        check("bas_ack4",  32'(bus2.ack0), 32'h0);
        check("bas_gnt4",  32'(bus2.gnt), 32'h0);
        check("bas_busy4", 32'(bus2.busy), 32'h0);
        check("bas_hold",  32'(bus2.sum), 32'h81);

        // overflow 0xFF + 0x01 on requester 1
        bus2.a1   = 8'hFF;
        bus2.b1   = 8'h01;
        bus2.req1 = 1'b1;
        step();
        check("ovf_gnt1", 32'(bus2.gnt), 32'h2);
        step();
        step();
        check("ovf_ack1", 32'(bus2.ack1), 32'h1);
        check("ovf_ack0", 32'(bus2.ack0), 32'h0);
        check("ovf_sum",  32'(bus2.sum), 32'h00);
        check("ovf_cout", 32'(bus2.cout), 32'h1);
        bus2.req1 = 1'b0;
        step();

        // both requesting: 0x12+0x34 and 0x80+0x90
        bus2.a0   = 8'h12;
        bus2.b0   = 8'h34;
        bus2.a1   = 8'h80;
        bus2.b1   = 8'h90;
        bus2.req0 = 1'b1;
        bus2.req1 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            ph  = (i - 1) % 4;
            own = ((i - 1) / 4) % 2;
            check("rr_gnt", 32'(bus2.gnt),
                  (ph < 3) ? ((own == 0) ? 32'h1 : 32'h2) : 32'h0);
            check("rr_ack0", 32'(bus2.ack0),
                  (ph == 2 && own == 0) ? 32'h1 : 32'h0);
            check("rr_ack1", 32'(bus2.ack1),
                  (ph == 2 && own == 1) ? 32'h1 : 32'h0);
            check("rr_excl", 32'(bus2.ack0 & bus2.ack1), 32'h0);
            if (ph == 2) begin
                check("rr_sum", 32'(bus2.sum),
                      (own == 0) ? 32'h46 : 32'h10);
                check("rr_cout", 32'(bus2.cout),
                      (own == 0) ? 32'h0 : 32'h1);
            end
            if (i == 16) begin
                bus2.req0 = 1'b0;
                bus2.req1 = 1'b0;
            end
        end
        step();
        check("rr_idle", 32'(bus2.busy), 32'h0);

        // operands change after grant must not matter
        bus2.a0   = 8'h10;
        bus2.b0   = 8'h01;
        bus2.req0 = 1'b1;
        step();
        check("chg_gnt", 32'(bus2.gnt), 32'h1);
        bus2.a0 = 8'hEE;
        step();
        step();
        check("chg_ack",  32'(bus2.ack0), 32'h1);
        check("chg_sum",  32'(bus2.sum), 32'h11);
        check("chg_cout", 32'(bus2.cout), 32'h0);
        bus2.req0 = 1'b0;
        step();

        // reset during the second CALC cycle
        bus2.a0   = 8'h22;
        bus2.b0   = 8'h33;
        bus2.req0 = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mrst_gnt",  32'(bus2.gnt), 32'h0);
        check("mrst_busy", 32'(bus2.busy), 32'h0);
        check("mrst_ack",  32'(bus2.ack0), 32'h0);
        check("mrst_sum",  32'(bus2.sum), 32'h0);
        check("mrst_adda", 32'(bus2.add_a), 32'h0);
        check("mrst_cin",  32'(bus2.add_cin), 32'h0);
        step();
        check("mrst_ack2", 32'(bus2.ack0), 32'h0);
        rst_n = 1'b1;
        step();
        check("mrst_gnt1", 32'(bus2.gnt), 32'h1);
        step();
        check("mrst_ack3", 32'(bus2.ack0), 32'h0);
        step();
        check("mrst_ack4", 32'(bus2.ack0), 32'h1);
        check("mrst_sum4", 32'(bus2.sum), 32'h55);
        bus2.req0 = 1'b0;
        step();

        // single nibble: 0x9 + 0x8
        bus1.a0   = 4'h9;
        bus1.b0   = 4'h8;
        bus1.req0 = 1'b1;
        step();
        check("n1_gnt",  32'(bus1.gnt), 32'h1);
        check("n1_adda", 32'(bus1.add_a), 32'h9);
        check("n1_addb", 32'(bus1.add_b), 32'h8);
        check("n1_cin",  32'(bus1.add_cin), 32'h0);
        check("n1_ack1", 32'(bus1.ack0), 32'h0);
        step();
        check("n1_ack2", 32'(bus1.ack0), 32'h1);
        check("n1_sum",  32'(bus1.sum), 32'h1);
        check("n1_cout", 32'(bus1.cout), 32'h1);
        bus1.req0 = 1'b0;
        step();
        check("n1_ack3", 32'(bus1.ack0), 32'h0);
        check("n1_hold", 32'(bus1.sum), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/add4_share_ctrl.md
# add4_share_ctrl

Sequencer and two-way arbiter for the shared 4-bit ripple-carry adder slice in the adder examples. It accepts multi-nibble add requests from two requesters and grants the slice to one requester at a time, round-robin. It then runs the operation nibble by nibble, least significant first, carrying between passes through an internal carry register. The registered sum and carry are returned with a one-cycle acknowledge. The adder slice is external to this block, combinational, and has a carry input.

## Interface
- NIBBLES, default 2: operand width in nibbles; legal range 1..4; W = 4*NIBBLES.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1 each  request from requester 0 / 1; held high until the matching ack.
- a0, b0 / a1, b1  in  W each  operands for requester 0 / 1.
- ack0 / ack1  out  1 each  one-cycle pulse; the result is valid in the same cycle.
- gnt  out  2  one-hot owner of the adder slice (bit0 = requester 0); 00 when idle.
- busy  out  1  high in CALC and DONE.
- sum  out  W  registered result; held until the next completion.
- cout  out  1  registered carry out of the top nibble.
- add_a, add_b  out  4 each  nibble operands driven to the adder slice.
- add_cin  out  1  carry input to the adder slice.
- add_sum  in  4  adder slice sum, same-cycle combinational return.
- add_cout  in  1  adder slice carry out.

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- Internal registers: opa, opb (W bits); res (W); carry; nibble index k; last (which requester was served last).
- IDLE:
  - If any req is high, select the owner, latch its a/b into opa/opb, clear carry and k, set gnt, go to CALC.
  - If both reqs are high, grant the requester that is not `last`.
  - `last` resets to 1, so requester 0 wins the first tie.
- CALC:
  - Drive add_a = opa[4k+3:4k], add_b = opb[4k+3:4k], add_cin = carry.
  - At the clock edge: res[4k+3:4k] <= add_sum, carry <= add_cout, k <= k+1.
  - When k = NIBBLES-1, load sum <= res with the final nibble merged in, load cout <= add_cout, and go to DONE.
- DONE:
  - Pulse ack of the owner for one cycle.
  - Update last to the owner, clear gnt, return to IDLE.
- In IDLE and DONE, add_a, add_b and add_cin are driven to 0.
- Arithmetic is unsigned modulo 2^W; overflow shows only on cout.
- Operands are latched at grant. Changes to a/b after the grant do not affect the result.
- A requester that drops req mid-operation still receives its ack, and the result is still delivered.
- A req still high in the IDLE cycle after its ack is treated as a new request. The round-robin rule still applies against the other requester.
- Reset asserted at any point aborts the operation: no ack is issued and all registers return to reset values.
- Reset values: gnt=00, ack0=ack1=0, busy=0, sum=0, cout=0, add_a=add_b=0, add_cin=0, state=IDLE, last=1, k=0, carry=0.

## Timing
- Cycle 0: req is sampled high in IDLE.
- Cycle 1: gnt and busy go high; the first CALC cycle begins.
- CALC occupies cycles 1..NIBBLES.
- Cycle NIBBLES+1: DONE. ack is high and sum/cout are valid.
- Latency from req sampled to ack is NIBBLES+1 cycles. Throughput is one operation per NIBBLES+2 cycles.
- sum and cout change only on the clock edge that enters DONE. They are stable from then until the next such edge.
- The adder path is combinational within a cycle: add_a/add_b/add_cin → add_sum/add_cout → res register.
- gnt is high exactly during the CALC cycles and the DONE cycle (NIBBLES+1 cycles total).

## Test plan
- Basic add, NIBBLES=2, after reset: req0 with a0=0x3C, b0=0x45.
  - gnt=01 in cycle 1.
  - add_cin=0 in cycle 1, add_cin=1 in cycle 2.
  - ack0 in cycle 3 with sum=0x81, cout=0.
- Overflow, NIBBLES=2: req1 with a1=0xFF, b1=0x01.
  - ack1 with sum=0x00, cout=1.
- Simultaneous requests: req0 and req1 held high continuously from reset.
  - Grants alternate 0,1,0,1.
  - ack pulses occur every 4 cycles.
  - ack0 and ack1 are never high together.
- Operand change after grant: a0 changes from 0x10 to 0xEE one cycle after gnt, with b0=0x01.
  - Result is 0x11, cout=0.
- Reset mid-operation: rst_n goes low during the second CALC cycle.
  - All outputs take reset values immediately, and no ack is issued.
  - After release with req0 still high, a fresh operation completes 3 cycles later.
- Single nibble, NIBBLES=1: a0=0x9, b0=0x8.
  - ack0 in cycle 2 with sum=0x1, cout=1.
